// File: rtl/binary_mul_acc_uni.sv
// -----------------------------------------------------------------------------
// binary_mul_acc_uni
//
// Accumulate stage that sits behind the unsigned 10x10 binary multiplier.
// It sums a frame of products into a dot product and offers the frame result
// downstream with a valid/ready handshake. The result is held until it is
// accepted.
//
// A frame ends on an accepted term flagged p_last, or on the MAX_TERMS-th
// accepted term. The sum wraps modulo 2^ACC_W, and ovf records that a wrap
// happened somewhere in the frame. After each transfer the stage spends one
// cycle before it can accept again.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   en        in   1      stage enable; 0 freezes the input side
//   p_valid   in   1      p_in carries a product this cycle
//   p_in      in   P_W    unsigned product from the multiplier
//   p_last    in   1      p_in is the final term of the frame
//   p_ready   out  1      stage accepts p_in this cycle (combinational)
//   out_ready in   1      consumer accepts the result this cycle
//   out_valid out  1      acc_out/term_cnt/ovf hold a completed frame
//   acc_out   out  ACC_W  frame sum
//   term_cnt  out  CNT_W  number of terms in the frame
//   ovf       out  1      sticky wrap flag for the frame
// -----------------------------------------------------------------------------
module binary_mul_acc_uni #(
  parameter int P_W       = 20,
  parameter int ACC_W     = 28,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             p_valid,
  input  logic [P_W-1:0]   p_in,
  input  logic             p_last,
  output logic             p_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_cnt,
  output logic             ovf
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc_q, acc_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               ovf_q, ovf_nxt;

  logic               accept;
  logic               frame_end;
  logic [ACC_W:0]     sum_ext;   // one extra bit holds the carry out

  assign p_ready   = (state == S_ACC) && en;
  assign accept    = p_valid && p_ready;
  assign sum_ext   = {1'b0, acc_q} + (ACC_W+1)'(p_in);
  assign frame_end = accept &&
                     (p_last || (cnt_q == CNT_W'(MAX_TERMS - 1)));

  // NOTE: every signal assigned in this block gets a default first, so a
  // path that leaves one untouched holds it instead of inferring a latch.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf_q;

    unique case (state)
      S_ACC: begin
        if (accept) begin
          acc_nxt = sum_ext[ACC_W-1:0];
          cnt_nxt = cnt_q + CNT_W'(1);
          ovf_nxt = ovf_q | sum_ext[ACC_W];
        end
        if (frame_end) begin
          state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        // The transfer does not depend on en: a frozen input side must not
        // stall a consumer that is ready to take the result.
        if (out_ready) begin
          state_nxt = S_ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end

      default: state_nxt = S_ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, and reset is
  // sampled on the clock edge (synchronous), so it overrides every other
  // input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACC;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc_q <= acc_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = (state == S_HOLD);
  assign acc_out   = acc_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_binary_mul_acc_uni.sv
// -----------------------------------------------------------------------------
// tb_binary_mul_acc_uni
//
// Drives two instances of the stage in lockstep: one uses the default 28-bit
// accumulator and one uses a 21-bit accumulator so that wrap behaviour shows
// up. A small reference model predicts p_ready/out_valid every cycle. Each
// completed frame is pushed to a scoreboard and popped when the transfer
// happens. Scenario tasks add explicit checks against hand-computed values.
// -----------------------------------------------------------------------------
module tb_binary_mul_acc_uni;

  localparam int P_W   = 20;
  localparam int CNT_W = 9;
  localparam int MAXT  = 256;

  logic              clk;
  logic              rst;
  logic              en;
  logic              p_valid;
  logic [P_W-1:0]    p_in;
  logic              p_last;
  logic              out_ready;

  logic              p_ready_a, p_ready_b;
  logic              out_valid_a, out_valid_b;
  logic [27:0]       acc_a;
  logic [20:0]       acc_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              ovf_a, ovf_b;

  binary_mul_acc_uni #(.P_W(P_W), .ACC_W(28), .MAX_TERMS(MAXT), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .en(en), .p_valid(p_valid), .p_in(p_in),
    .p_last(p_last), .p_ready(p_ready_a), .out_ready(out_ready),
    .out_valid(out_valid_a), .acc_out(acc_a), .term_cnt(cnt_a), .ovf(ovf_a)
  );

  binary_mul_acc_uni #(.P_W(P_W), .ACC_W(21), .MAX_TERMS(MAXT), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .en(en), .p_valid(p_valid), .p_in(p_in),
    .p_last(p_last), .p_ready(p_ready_b), .out_ready(out_ready),
    .out_valid(out_valid_b), .acc_out(acc_b), .term_cnt(cnt_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [27:0]      acc_a;
    logic [20:0]      acc_b;
    logic [CNT_W-1:0] cnt;
    logic             ovf_a;
    logic             ovf_b;
  } frame_t;

  frame_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic             m_hold;
  logic [27:0]      m_acc_a;
  logic [20:0]      m_acc_b;
  int               m_cnt;
  logic             m_ovf_a, m_ovf_b;

  task automatic model_clear();
    m_hold  = 1'b0;
    m_acc_a = '0;
    m_acc_b = '0;
    m_cnt   = 0;
    m_ovf_a = 1'b0;
    m_ovf_b = 1'b0;
  endtask

  // One clock cycle. It is entered and left just after a falling edge, so
  // outputs are always sampled away from the rising edge.
  task automatic step(input logic v, input logic [P_W-1:0] d, input logic l,
                      input logic e, input logic r);
    logic     exp_ready;
    logic [28:0] s_a;
    logic [21:0] s_b;
    frame_t   f;
    p_valid   = v;
    p_in      = d;
    p_last    = l;
    en        = e;
    out_ready = r;
    #1;
    exp_ready = !m_hold && e;
    n_cmp++;
    if ({p_ready_a, p_ready_b} !== {exp_ready, exp_ready}) begin
      n_err++;
      $display("FAIL p_ready: got a=%b b=%b, expected %b", p_ready_a, p_ready_b, exp_ready);
    end
    if (m_hold && r) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: transfer with no expected frame");
      end else begin
        f = sb.pop_front();
        if (acc_a !== f.acc_a || acc_b !== f.acc_b || cnt_a !== f.cnt ||
            cnt_b !== f.cnt || ovf_a !== f.ovf_a || ovf_b !== f.ovf_b) begin
          n_err++;
          $display("FAIL frame: got acc=%0d/%0d cnt=%0d/%0d ovf=%b/%b, expected acc=%0d/%0d cnt=%0d ovf=%b/%b",
                   acc_a, acc_b, cnt_a, cnt_b, ovf_a, ovf_b,
                   f.acc_a, f.acc_b, f.cnt, f.ovf_a, f.ovf_b);
        end
      end
      model_clear();
    end else if (v && exp_ready) begin
      s_a     = {1'b0, m_acc_a} + 29'(d);
      s_b     = {1'b0, m_acc_b} + 22'(d);
      m_acc_a = s_a[27:0];
      m_acc_b = s_b[20:0];
      m_ovf_a = m_ovf_a | s_a[28];
      m_ovf_b = m_ovf_b | s_b[21];
      m_cnt   = m_cnt + 1;
      if (l || m_cnt == MAXT) begin
        m_hold  = 1'b1;
        f.acc_a = m_acc_a;
        f.acc_b = m_acc_b;
        f.cnt   = CNT_W'(m_cnt);
        f.ovf_a = m_ovf_a;
        f.ovf_b = m_ovf_b;
        sb.push_back(f);
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid_a, out_valid_b} !== {m_hold, m_hold}) begin
      n_err++;
      $display("FAIL out_valid: got a=%b b=%b, expected %b", out_valid_a, out_valid_b, m_hold);
    end
  endtask

  // One cycle with rst high, while p_valid is also asserted to show that
  // reset wins. All outputs must read zero afterwards.
  task automatic reset_cycle(input string tag);
    rst       = 1'b1;
    en        = 1'b1;
    p_valid   = 1'b1;
    p_in      = 20'd777;
    p_last    = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    sb.delete();
    n_cmp++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || acc_a !== '0 || acc_b !== '0 ||
        cnt_a !== '0 || cnt_b !== '0 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got v=%b/%b acc=%0d/%0d cnt=%0d/%0d ovf=%b/%b, expected all 0",
               tag, out_valid_a, out_valid_b, acc_a, acc_b, cnt_a, cnt_b, ovf_a, ovf_b);
    end
  endtask

  task automatic test_reset();
    reset_cycle("reset_state");
  endtask

  task automatic test_basic_frame();
    step(1'b1, 20'd6, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd35, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd1046529, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid_a !== 1'b1 || acc_a !== 28'd1046570 || cnt_a !== 9'd3 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got v=%b acc=%0d cnt=%0d ovf=%b, expected 1 1046570 3 0",
               out_valid_a, acc_a, cnt_a, ovf_a);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid_a !== 1'b0 || acc_a !== 28'd0) begin
      n_err++;
      $display("FAIL basic_clear: got v=%b acc=%0d, expected 0 0", out_valid_a, acc_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < MAXT; i++) begin
      step(1'b1, 20'd1046529, 1'b0, 1'b1, 1'b1);
    end
    n_cmp++;
    if (out_valid_a !== 1'b1 || acc_a !== 28'd267911424 || cnt_a !== 9'd256 || ovf_a !== 1'b0) begin
      n_err++;
      $display("FAIL max_terms: got v=%b acc=%0d cnt=%0d ovf=%b, expected 1 267911424 256 0",
               out_valid_a, acc_a, cnt_a, ovf_a);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    step(1'b1, 20'd1046529, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd1046529, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd1046529, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (acc_b !== 21'd1042435 || ovf_b !== 1'b1 || cnt_b !== 9'd3) begin
      n_err++;
      $display("FAIL wrap: got acc=%0d ovf=%b cnt=%0d, expected 1042435 1 3", acc_b, ovf_b, cnt_b);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (ovf_b !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_clear: got ovf=%b, expected 0", ovf_b);
    end
  endtask

  task automatic test_hold();
    step(1'b1, 20'd100, 1'b0, 1'b1, 1'b0);
    step(1'b1, 20'd200, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 20'd7, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (acc_a !== 28'd300 || cnt_a !== 9'd2) begin
        n_err++;
        $display("FAIL hold_stable: got acc=%0d cnt=%0d, expected 300 2", acc_a, cnt_a);
      end
    end
    step(1'b1, 20'd7, 1'b0, 1'b1, 1'b1);   // transfer cycle, nothing accepted
    n_cmp++;
    if (out_valid_a !== 1'b0 || cnt_a !== 9'd0) begin
      n_err++;
      $display("FAIL hold_transfer: got v=%b cnt=%0d, expected 0 0", out_valid_a, cnt_a);
    end
    step(1'b1, 20'd7, 1'b1, 1'b1, 1'b1);   // first accept after the bubble
    n_cmp++;
    if (out_valid_a !== 1'b1 || acc_a !== 28'd7 || cnt_a !== 9'd1) begin
      n_err++;
      $display("FAIL hold_first_accept: got v=%b acc=%0d cnt=%0d, expected 1 7 1",
               out_valid_a, acc_a, cnt_a);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_enable();
    step(1'b1, 20'd10, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd20, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 20'd999, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (cnt_a !== 9'd2 || acc_a !== 28'd30 || out_valid_a !== 1'b0) begin
        n_err++;
        $display("FAIL enable_freeze: got cnt=%0d acc=%0d v=%b, expected 2 30 0",
                 cnt_a, acc_a, out_valid_a);
      end
    end
    step(1'b1, 20'd30, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid_a !== 1'b1 || acc_a !== 28'd60 || cnt_a !== 9'd3) begin
      n_err++;
      $display("FAIL enable_resume: got v=%b acc=%0d cnt=%0d, expected 1 60 3",
               out_valid_a, acc_a, cnt_a);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 20'd50, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd60, 1'b0, 1'b1, 1'b1);
    reset_cycle("reset_partial");
    step(1'b1, 20'd11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 20'd22, 1'b1, 1'b1, 1'b0);
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b0);
    reset_cycle("reset_hold");
    step(1'b1, 20'd4, 1'b0, 1'b1, 1'b1);
    step(1'b1, 20'd5, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid_a !== 1'b1 || acc_a !== 28'd9 || cnt_a !== 9'd2) begin
      n_err++;
      $display("FAIL reset_new_frame: got v=%b acc=%0d cnt=%0d, expected 1 9 2",
               out_valid_a, acc_a, cnt_a);
    end
    step(1'b0, 20'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    p_valid   = 1'b0;
    p_in      = '0;
    p_last    = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_wrap();
    test_hold();
    test_enable();
    test_reset_mid();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending frames, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
